// File: rtl/lc3_writeback_rf.sv
// rtl/lc3_writeback_rf.sv - LC-3 writeback stage: source mux, 8-entry register file, N/Z/P flags
// Optional zero-cycle write-to-read forwarding when WB_BYPASS_EN is defined.
module lc3_writeback_rf #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable_writeback,
    input  logic [1:0]            W_Control,
    input  logic [DATA_WIDTH-1:0] aluout,
    input  logic [DATA_WIDTH-1:0] memout,
    input  logic [DATA_WIDTH-1:0] pcout,
    input  logic [ADDR_WIDTH-1:0] dr,
    input  logic [ADDR_WIDTH-1:0] sr1,
    input  logic [ADDR_WIDTH-1:0] sr2,
    output logic [2:0]            psr,
    output logic [DATA_WIDTH-1:0] vsr1,
    output logic [DATA_WIDTH-1:0] vsr2
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] wdata;
    logic                  write_en;
    logic [2:0]            next_flags;

    always_comb begin
        wdata = '0;
        case (W_Control)
            2'd0:    wdata = aluout;
            2'd1:    wdata = memout;
            2'd2:    wdata = pcout;
            default: wdata = '0;
        endcase
    end

    // Source code 3 is reserved and suppresses the whole commit, flags included.
    assign write_en = enable_writeback && (W_Control != 2'd3);

    always_comb begin
        next_flags = 3'b001;
        if (wdata[DATA_WIDTH-1])
            next_flags = 3'b100;
        else if (wdata == '0)
            next_flags = 3'b010;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            psr <= 3'b000;
        end else if (write_en) begin
            regs[dr] <= wdata;
            psr      <= next_flags;
        end
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        vsr1 = regs[sr1];
        vsr2 = regs[sr2];
        if (write_en && (sr1 == dr))
            vsr1 = wdata;
        if (write_en && (sr2 == dr))
            vsr2 = wdata;
    end
`else
    assign vsr1 = regs[sr1];
    assign vsr2 = regs[sr2];
`endif

endmodule

// File: tb/tb_lc3_writeback_rf.sv
// tb/tb_lc3_writeback_rf.sv - directed and randomized checks of lc3_writeback_rf against a reference model
module tb_lc3_writeback_rf;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_writeback;
    logic [1:0]  W_Control;
    logic [15:0] aluout, memout, pcout;
    logic [2:0]  dr, sr1, sr2;
    logic [2:0]  psr;
    logic [15:0] vsr1, vsr2;

    int errors = 0;
    int checks = 0;

    logic [15:0] model_rf [8];
    logic [2:0]  model_psr;

    always #5 clock = ~clock;

    lc3_writeback_rf dut (
        .clock(clock), .reset(reset), .enable_writeback(enable_writeback),
        .W_Control(W_Control), .aluout(aluout), .memout(memout), .pcout(pcout),
        .dr(dr), .sr1(sr1), .sr2(sr2), .psr(psr), .vsr1(vsr1), .vsr2(vsr2)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] flags_of(input logic [15:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 16'h0000)  return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [15:0] pick(input logic [1:0] wc, input logic [15:0] a,
                                         input logic [15:0] m, input logic [15:0] p);
        return (wc == 2'd0) ? a : (wc == 2'd1) ? m : p;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) model_rf[i] = 16'h0000;
        model_psr = 3'b000;
    endtask

    // One clock: drive at negedge, check reads before the edge, then retire into the model.
    task automatic cycle(input string tag, input logic en, input logic [1:0] wc,
                         input logic [15:0] a, input logic [15:0] m, input logic [15:0] p,
                         input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
        logic [15:0] e1, e2, wv;
        logic        commit;
        @(negedge clock);
        enable_writeback = en; W_Control = wc; aluout = a; memout = m; pcout = p;
        dr = d; sr1 = s1; sr2 = s2;
        #1;
        wv     = pick(wc, a, m, p);
        commit = en && (wc != 2'd3);
        e1     = model_rf[s1];
        e2     = model_rf[s2];
`ifdef WB_BYPASS_EN
        if (commit && s1 == d) e1 = wv;
        if (commit && s2 == d) e2 = wv;
`endif
        check({tag, "_vsr1"}, vsr1, e1);
        check({tag, "_vsr2"}, vsr2, e2);
        check({tag, "_psr"}, {13'd0, psr}, {13'd0, model_psr});
        @(posedge clock);
        if (commit) begin
            model_rf[d] = wv;
            model_psr   = flags_of(wv);
        end
    endtask

    task automatic look(input string tag, input logic [2:0] s1, input logic [2:0] s2,
                        input logic [15:0] e1, input logic [15:0] e2, input logic [2:0] ep);
        @(negedge clock);
        enable_writeback = 1'b0; sr1 = s1; sr2 = s2;
        #1;
        check({tag, "_vsr1"}, vsr1, e1);
        check({tag, "_vsr2"}, vsr2, e2);
        check({tag, "_psr"}, {13'd0, psr}, {13'd0, ep});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ra, rm, rp;
        reset = 1'b0; enable_writeback = 1'b0; W_Control = 2'd0;
        aluout = '0; memout = '0; pcout = '0; dr = '0; sr1 = '0; sr2 = '0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        check("rst_vsr1", vsr1, 16'h0000);
        check("rst_vsr2", vsr2, 16'h0000);
        check("rst_psr", {13'd0, psr}, 16'h0000);
        @(negedge clock);
        reset = 1'b1;

        // Source select and flags
        cycle("w_alu", 1, 2'd0, 16'h8001, 16'h1111, 16'h2222, 3'd2, 3'd0, 3'd0);
        look("r2", 3'd2, 3'd2, 16'h8001, 16'h8001, 3'b100);
        cycle("w_mem", 1, 2'd1, 16'h4444, 16'h0000, 16'h2222, 3'd5, 3'd5, 3'd2);
        look("r5", 3'd5, 3'd2, 16'h0000, 16'h8001, 3'b010);
        cycle("w_pc", 1, 2'd2, 16'h4444, 16'h5555, 16'h3005, 3'd7, 3'd7, 3'd5);
        look("r7", 3'd7, 3'd5, 16'h3005, 16'h0000, 3'b001);

        // Hold cases
        cycle("hold_en", 0, 2'd0, 16'hFFFF, 16'h0000, 16'h0000, 3'd2, 3'd2, 3'd7);
        look("hold_en_after", 3'd2, 3'd7, 16'h8001, 16'h3005, 3'b001);
        cycle("hold_wc3", 1, 2'd3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'd2, 3'd2, 3'd2);
        look("hold_wc3_after", 3'd2, 3'd2, 16'h8001, 16'h8001, 3'b001);

        // Dual read
        cycle("w_r1", 1, 2'd0, 16'h00AA, 16'h0, 16'h0, 3'd1, 3'd0, 3'd0);
        cycle("w_r6", 1, 2'd1, 16'h0, 16'h5500, 16'h0, 3'd6, 3'd0, 3'd0);
        look("dual", 3'd1, 3'd6, 16'h00AA, 16'h5500, 3'b001);
        look("same", 3'd6, 3'd6, 16'h5500, 16'h5500, 3'b001);

        // Read during write
        cycle("w_r4", 1, 2'd0, 16'h0011, 16'h0, 16'h0, 3'd4, 3'd0, 3'd0);
        cycle("rdw", 1, 2'd0, 16'h0022, 16'h0, 16'h0, 3'd4, 3'd4, 3'd1);
`ifdef WB_BYPASS_EN
        check("rdw_bypass_lit", vsr1, 16'h0022);
`else
        check("rdw_old_lit", vsr1, 16'h0011);
`endif
        look("rdw_after", 3'd4, 3'd1, 16'h0022, 16'h00AA, 3'b001);

        // Back-to-back writes to R0
        cycle("b2b_a", 1, 2'd0, 16'h7FFF, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0);
        #1 check("b2b_a_psr", {13'd0, psr}, 16'h0001);
        cycle("b2b_b", 1, 2'd0, 16'hFFFE, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0);
        #1 check("b2b_b_psr", {13'd0, psr}, 16'h0004);
        look("r0", 3'd0, 3'd0, 16'hFFFE, 16'hFFFE, 3'b100);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            rm = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
            rp = 16'($urandom);
            cycle("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), ra, rm, rp,
                  3'($urandom), 3'($urandom), 3'($urandom));
        end

        // Asynchronous reset mid-cycle with a pending write
        cycle("w_r3", 1, 2'd0, 16'h1234, 16'h0, 16'h0, 3'd3, 3'd3, 3'd3);
        look("r3", 3'd3, 3'd3, 16'h1234, 16'h1234, 3'b001);
        @(negedge clock);
        enable_writeback = 1'b1; W_Control = 2'd0; aluout = 16'hFFFF; dr = 3'd3; sr1 = 3'd3;
        #1 reset = 1'b0;
        #1;
        check("arst_psr", {13'd0, psr}, 16'h0000);
        check("arst_vsr1", vsr1, 16'h0000);
        model_clear();
        @(posedge clock);
        @(negedge clock);
        enable_writeback = 1'b0;
        reset = 1'b1;
        #1;
        check("arst_rel_vsr1", vsr1, 16'h0000);
        check("arst_rel_psr", {13'd0, psr}, 16'h0000);
        cycle("post_rst", 0, 2'd0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd3, 3'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
